// File: rtl/alu_ctrl_gen_pipe_pkg.sv
// Shared opcode/funct encodings and default widths for the ALU funct generator.
package alu_ctrl_gen_pipe_pkg;

    localparam int LANES_DEF   = 1;
    localparam int OP_W_DEF    = 6;
    localparam int FUNCT_W_DEF = 6;
    localparam int CNT_W_DEF   = 16;

    typedef logic [OP_W_DEF-1:0]    op_t;
    typedef logic [FUNCT_W_DEF-1:0] funct_t;

    // Primary opcodes
    localparam op_t OP_SPECIAL = 6'b000000;
    localparam op_t OP_J       = 6'b000010;
    localparam op_t OP_JAL     = 6'b000011;
    localparam op_t OP_BEQ     = 6'b000100;
    localparam op_t OP_BNE     = 6'b000101;
    localparam op_t OP_ADDI    = 6'b001000;
    localparam op_t OP_ADDIU   = 6'b001001;
    localparam op_t OP_SLTI    = 6'b001010;
    localparam op_t OP_SLTIU   = 6'b001011;
    localparam op_t OP_ANDI    = 6'b001100;
    localparam op_t OP_ORI     = 6'b001101;
    localparam op_t OP_XORI    = 6'b001110;
    localparam op_t OP_LUI     = 6'b001111;
    localparam op_t OP_LB      = 6'b100000;
    localparam op_t OP_LH      = 6'b100001;
    localparam op_t OP_LW      = 6'b100011;
    localparam op_t OP_LBU     = 6'b100100;
    localparam op_t OP_LHU     = 6'b100101;
    localparam op_t OP_SB      = 6'b101000;
    localparam op_t OP_SH      = 6'b101001;
    localparam op_t OP_SW      = 6'b101011;

    // ALU funct codes
    localparam funct_t FUNCT_NOP  = 6'b000000;
    localparam funct_t FUNCT_ADD  = 6'b100000;
    localparam funct_t FUNCT_ADDU = 6'b100001;
    localparam funct_t FUNCT_AND  = 6'b100100;
    localparam funct_t FUNCT_OR   = 6'b100101;
    localparam funct_t FUNCT_XOR  = 6'b100110;
    localparam funct_t FUNCT_SLT  = 6'b101010;
    localparam funct_t FUNCT_SLTU = 6'b101011;

endpackage

// File: rtl/alu_ctrl_lane_map.sv
// Combinational opcode/funct -> ALU funct map for one lane.
// Define ALU_CTRL_SIGNED_OPS_EN to map ADDI/SLTI to ADD/SLT; otherwise they are illegal.
module alu_ctrl_lane_map
    import alu_ctrl_gen_pipe_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int FUNCT_W = FUNCT_W_DEF
) (
    input  logic               lane_en,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic               illegal
);

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        alu_funct = FUNCT_NOP;
        illegal   = 1'b0;
        if (lane_en) begin
            case (op)
                OP_SPECIAL:                        alu_funct = funct;
                OP_ORI, OP_LUI, OP_JAL:            alu_funct = FUNCT_OR;
                OP_LB, OP_LBU, OP_LH, OP_LHU,
                OP_LW, OP_SB, OP_SH, OP_SW,
                OP_ADDIU:                          alu_funct = FUNCT_ADDU;
                OP_ANDI:                           alu_funct = FUNCT_AND;
                OP_XORI:                           alu_funct = FUNCT_XOR;
                OP_SLTIU:                          alu_funct = FUNCT_SLTU;
                OP_BEQ, OP_BNE, OP_J:              alu_funct = FUNCT_NOP;
`ifdef ALU_CTRL_SIGNED_OPS_EN
                OP_ADDI:                           alu_funct = FUNCT_ADD;
                OP_SLTI:                           alu_funct = FUNCT_SLT;
`endif
                default:                           illegal   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_gen_pipe.sv
// Multi-lane registered ALU funct generator with a 2-entry skid buffer and
// a saturating illegal-opcode counter.
module alu_ctrl_gen_pipe
    import alu_ctrl_gen_pipe_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int FUNCT_W = FUNCT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_en,
    input  logic [LANES*OP_W-1:0]    in_op,
    input  logic [LANES*FUNCT_W-1:0] in_funct,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_en,
    output logic [LANES*FUNCT_W-1:0] out_funct,
    output logic [LANES-1:0]         out_illegal,
    output logic [CNT_W-1:0]         illegal_cnt
);

    localparam int               SUM_W   = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LANES*FUNCT_W-1:0] map_funct;
    logic [LANES-1:0]         map_illegal;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_ctrl_lane_map #(
            .OP_W    (OP_W),
            .FUNCT_W (FUNCT_W)
        ) u_map (
            .lane_en   (in_lane_en[i]),
            .op        (in_op[i*OP_W +: OP_W]),
            .funct     (in_funct[i*FUNCT_W +: FUNCT_W]),
            .alu_funct (map_funct[i*FUNCT_W +: FUNCT_W]),
            .illegal   (map_illegal[i])
        );
    end

    logic                     skid_valid;
    logic [LANES-1:0]         skid_lane_en;
    logic [LANES*FUNCT_W-1:0] skid_funct;
    logic [LANES-1:0]         skid_illegal;
    logic                     accept;
    logic                     main_free;

    // Ready comes straight from a flop, so no combinational path from out_ready.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign main_free = ~out_valid | out_ready;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_lane_en <= '0;
            out_funct   <= '0;
            out_illegal <= '0;
            skid_valid  <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_lane_en <= skid_lane_en;
                out_funct   <= skid_funct;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
            end
        end else if (accept) begin
            if (main_free) begin
                out_valid   <= 1'b1;
                out_lane_en <= in_lane_en;
                out_funct   <= map_funct;
                out_illegal <= map_illegal;
            end else begin
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: skid payload needs no reset; skid_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (accept && !main_free) begin
            skid_lane_en <= in_lane_en;
            skid_funct   <= map_funct;
            skid_illegal <= map_illegal;
        end
    end

    logic [2:0]       inc;
    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        inc = '0;
        for (int i = 0; i < LANES; i++) begin
            inc = inc + {2'b00, map_illegal[i]};
        end
        cnt_sum = {3'b000, illegal_cnt} + SUM_W'(inc);
    end

    // Counted at acceptance, so beats later discarded by flush still count.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept) begin
            if (cnt_sum > {3'b000, CNT_MAX}) illegal_cnt <= CNT_MAX;
            else                             illegal_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_alu_ctrl_gen_pipe.sv
// Randomized self-checking bench for alu_ctrl_gen_pipe against a queue-based reference model.
module tb_alu_ctrl_gen_pipe;

    localparam int LANES = 2;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [1:0]  en;
        logic [11:0] funct;
        logic [1:0]  ill;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_lane_en, out_lane_en, out_illegal;
    logic [11:0] in_op, in_funct, out_funct;
    logic [2:0]  illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t q[$];
    int    ref_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl_gen_pipe #(.LANES(LANES), .OP_W(6), .FUNCT_W(6), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane_en  (in_lane_en),
        .in_op       (in_op),
        .in_funct    (in_funct),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane_en (out_lane_en),
        .out_funct   (out_funct),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written as an instruction-set table: returns {illegal, funct}.
    function automatic logic [6:0] ref_lane(input logic en, input logic [5:0] op, input logic [5:0] fn);
        if (!en) return 7'b0_000000;
        case (op)
            6'b000000: return {1'b0, fn};            // SPECIAL
            6'b001101, 6'b001111, 6'b000011:
                       return {1'b0, 6'b100101};     // ORI LUI JAL -> OR
            6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
            6'b101000, 6'b101001, 6'b101011, 6'b001001:
                       return {1'b0, 6'b100001};     // loads/stores/ADDIU -> ADDU
            6'b001100: return {1'b0, 6'b100100};     // ANDI
            6'b001110: return {1'b0, 6'b100110};     // XORI
            6'b001011: return {1'b0, 6'b101011};     // SLTIU
            6'b000100, 6'b000101, 6'b000010:
                       return 7'b0_000000;           // BEQ BNE J
`ifdef ALU_CTRL_SIGNED_OPS_EN
            6'b001000: return {1'b0, 6'b100000};     // ADDI -> ADD
            6'b001010: return {1'b0, 6'b101010};     // SLTI -> SLT
`endif
            default:   return 7'b1_000000;
        endcase
    endfunction

    function automatic beat_t ref_beat(input logic [1:0] en, input logic [11:0] op, input logic [11:0] fn);
        beat_t b;
        logic [6:0] l0, l1;
        l0 = ref_lane(en[0], op[5:0], fn[5:0]);
        l1 = ref_lane(en[1], op[11:6], fn[11:6]);
        b.en    = en;
        b.funct = {l1[5:0], l0[5:0]};
        b.ill   = {l1[6], l0[6]};
        return b;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input logic r, input logic f, input logic v, input logic [1:0] en,
                         input logic [11:0] op, input logic [11:0] fn, input logic ordy);
        beat_t b;
        int    sz;
        rst = r; flush = f; in_valid = v; in_lane_en = en; in_op = op; in_funct = fn; out_ready = ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            ref_cnt = 0;
        end else if (f) begin
            q.delete();
        end else begin
            sz = q.size();
            if (sz > 0 && ordy) void'(q.pop_front());
            if (v && sz < 2) begin
                b = ref_beat(en, op, fn);
                q.push_back(b);
                ref_cnt = ref_cnt + $countones(b.ill);
                if (ref_cnt > 7) ref_cnt = 7;
            end
        end
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("illegal_cnt", 32'(illegal_cnt), 32'(ref_cnt));
        if (q.size() > 0) begin
            check("out_lane_en", 32'(out_lane_en), 32'(q[0].en));
            check("out_funct", 32'(out_funct), 32'(q[0].funct));
            check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 12'h0, 12'h0, ordy);
    endtask

    logic [5:0] pool [24] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000,
                              6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110,
                              6'b001111, 6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                              6'b101000, 6'b101001, 6'b101011, 6'b111111, 6'b010000, 6'b110001};

    function automatic logic [5:0] rand_op();
        if ($urandom_range(3) == 0) return 6'($urandom);
        return pool[$urandom_range(23)];
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_lane_en = '0;
        in_op = '0; in_funct = '0; out_ready = 1'b0;

        // Reset values
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 12'h0, 12'h0, 1'b0);
        check("rst_out_funct", 32'(out_funct), 32'h0);
        check("rst_out_lane_en", 32'(out_lane_en), 32'h0);
        check("rst_out_illegal", 32'(out_illegal), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // ORI on lane0, LW on lane1
        cycle(1'b0, 1'b0, 1'b1, 2'b11, {6'b100011, 6'b001101}, 12'h0, 1'b1);
        check("ori_lw_funct", 32'(out_funct), 32'({6'b100001, 6'b100101}));
        check("ori_lw_illegal", 32'(out_illegal), 32'h0);

        // SPECIAL on lane0, lane1 disabled with an unmapped opcode
        cycle(1'b0, 1'b0, 1'b1, 2'b01, {6'b111111, 6'b000000}, {6'b000000, 6'b101010}, 1'b1);
        check("special_funct", 32'(out_funct), 32'({6'b000000, 6'b101010}));
        check("special_lane_en", 32'(out_lane_en), 32'h1);
        check("special_illegal", 32'(out_illegal), 32'h0);
        idle(1'b1);

        // Stall: A then B with out_ready low fills both slots
        cycle(1'b0, 1'b0, 1'b1, 2'b11, {6'b001100, 6'b001110}, 12'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b11, {6'b001011, 6'b001111}, 12'h0, 1'b0);
        check("stall_in_ready", 32'(in_ready), 32'h0);
        check("stall_hold_a", 32'(out_funct), 32'({6'b100100, 6'b100110}));
        cycle(1'b0, 1'b0, 1'b1, 2'b11, {6'b000100, 6'b000100}, 12'h0, 1'b0);
        check("stall_still_a", 32'(out_funct), 32'({6'b100100, 6'b100110}));
        idle(1'b1);
        check("drain_b", 32'(out_funct), 32'({6'b101011, 6'b100101}));
        check("drain_in_ready", 32'(in_ready), 32'h1);
        idle(1'b1);
        check("drain_empty", 32'(out_valid), 32'h0);

        // Flush with skid full and a same-cycle input
        cycle(1'b0, 1'b0, 1'b1, 2'b11, {6'b001101, 6'b001101}, 12'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b11, {6'b001110, 6'b001110}, 12'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 2'b11, {6'b001100, 6'b001100}, 12'h0, 1'b0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);
        idle(1'b1);
        check("flush_dropped", 32'(out_valid), 32'h0);

        // Counter saturation at CNT_W=3
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 12'h0, 12'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 2'b11, 12'hFFF, 12'h0, 1'b1);
            check("sat_cnt", 32'(illegal_cnt), (i < 3) ? 32'(2 * (i + 1)) : 32'd7);
        end
        check("sat_illegal", 32'(out_illegal), 32'h3);

        // Counter survives flush, cleared only by reset
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 12'hFFF, 12'h0, 1'b1);
        check("cnt_after_flush", 32'(illegal_cnt), 32'd7);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 12'h0, 12'h0, 1'b1);
        check("cnt_after_rst", 32'(illegal_cnt), 32'd0);

        // ADDI on lane0
        cycle(1'b0, 1'b0, 1'b1, 2'b01, {6'b000000, 6'b001000}, 12'h0, 1'b1);
`ifdef ALU_CTRL_SIGNED_OPS_EN
        check("addi_funct", 32'(out_funct), 32'({6'b000000, 6'b100000}));
        check("addi_illegal", 32'(out_illegal), 32'h0);
        check("addi_cnt", 32'(illegal_cnt), 32'd0);
`else
        check("addi_funct", 32'(out_funct), 32'h0);
        check("addi_illegal", 32'(out_illegal), 32'h1);
        check("addi_cnt", 32'(illegal_cnt), 32'd1);
`endif

        // Mid-stall reset loses pending beats
        cycle(1'b0, 1'b0, 1'b1, 2'b11, 12'h345, 12'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b11, 12'h346, 12'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 2'b11, 12'h347, 12'h0, 1'b0);
        check("rst_stall_valid", 32'(out_valid), 32'h0);
        check("rst_stall_ready", 32'(in_ready), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(19) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(9) < 7) ? 1'b1 : 1'b0,
                  2'($urandom),
                  {rand_op(), rand_op()},
                  12'($urandom),
                  ($urandom_range(9) < 6) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_gen_pipe.md
Name: alu_ctrl_gen_pipe

Overview:
- Registered, multi-lane successor to the ID-stage ALU funct generator.
- Maps each lane's instruction opcode (and SPECIAL funct field) to the ALU funct code.
- Flags illegal opcodes and counts them.
- Carries results through a 2-entry skid buffer with valid/ready handshake, so ID/EX can stall and flush without combinational ready paths.

Parameters:
- LANES, 1, number of instructions decoded per beat (1..4).
- OP_W, 6, opcode width.
- FUNCT_W, 6, funct width.
- CNT_W, 16, width of saturating illegal-op counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered beats and any beat offered this cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  buffer can accept a beat; registered, depends only on skid occupancy.
- in_lane_en  in  LANES  per-lane instruction present.
- in_op  in  LANES*OP_W  lane i at bits [i*OP_W +: OP_W].
- in_funct  in  LANES*FUNCT_W  instruction funct field per lane.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_lane_en  out  LANES  registered copy of in_lane_en.
- out_funct  out  LANES*FUNCT_W  generated ALU funct per lane.
- out_illegal  out  LANES  lane enabled and opcode unmapped.
- illegal_cnt  out  CNT_W  saturating count of illegal lanes accepted.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_lane_en=0, out_funct=0 (NOP), out_illegal=0, illegal_cnt=0, skid empty, in_ready=1 from the next cycle.
- Mapping per lane, combinational before capture:
  - SPECIAL(000000) → in_funct.
  - ORI/LUI/JAL → OR(100101).
  - LB/LBU/LH/LHU/LW/SB/SH/SW/ADDIU → ADDU(100001).
  - ANDI → AND(100100).
  - XORI → XOR(100110).
  - SLTIU → SLTU(101011).
  - BEQ/BNE/J → NOP(000000), not illegal.
  - ADDI/SLTI: see Optional Feature.
  - Any other opcode → NOP with illegal=1.
  - Disabled lanes: funct=NOP, illegal=0.
- Accept: in_valid && in_ready && !flush. Latency 1: an accepted beat with the main slot empty or draining (out_ready=1) appears on out_* the next cycle.
- Main slot full and out_ready=0: accepted beat goes to the skid slot. in_ready drops to 0 the following cycle.
- Skid full and out_ready=1: skid moves to main, skid empties, in_ready=1 next cycle. A beat arriving in the same cycle is not accepted, because in_ready=0.
- Order is preserved; no beat is duplicated or lost except by flush.
- out_* are held stable while out_valid && !out_ready.
- flush: next cycle out_valid=0, skid empty, in_ready=1. A same-cycle input beat is dropped. flush has priority over acceptance and over draining.
- illegal_cnt increments by popcount(out_illegal) of each accepted beat and saturates at 2^CNT_W-1. It is not cleared by flush, only by rst.
- rst mid-stall behaves exactly like the reset values above; pending beats are lost.

Optional Feature:
- Macro ALU_CTRL_SIGNED_OPS_EN.
- Defined: ADDI(001000) → ADD(100000); SLTI(001010) → SLT(101010). Neither is illegal.
- Undefined: ADDI and SLTI are unmapped: funct=NOP, illegal=1, counted.

Decomposition:
- Shared package/header holds the opcode constants (OP_*), funct constants (FUNCT_*), and the default widths.
- One natural sub-module, alu_ctrl_lane_map: purely combinational op/funct → funct/illegal for one lane, instantiated LANES times.
- The top level holds the skid buffer, handshake, and counter.

Test Plan:
- LANES=2, reset, then one beat: op0=ORI, op1=LW, both enabled, out_ready=1 → next cycle out_valid=1, out_funct={100001,100101}, out_illegal=00, illegal_cnt=0.
- SPECIAL with in_funct=101010 on lane0, lane1 disabled → lane0 funct 101010, lane1 000000, out_lane_en=01.
- Hold out_ready=0; push beats A, B → in_ready=0 the cycle after B. Raise out_ready → A then B on consecutive cycles, in_ready=1 after skid empties.
- Skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input never appears.
- Opcode 111111 on both lanes for 3 beats with CNT_W=3 → illegal_cnt 2,4,6. A further beat saturates at 7.
- ADDI on lane0: with macro → funct 100000, illegal=0. Without macro → funct 000000, illegal=1, counter +1.
